// File: rtl/fetch_decode_ctrl_if.sv
// Control bundle between the fetch/decode sequencer and its datapath.
// master: the sequencer (drives strobes/status); slave: the datapath/stimulus side.
interface fetch_decode_ctrl_if #(
  parameter int CNT_W = 8
);
  logic             start;
  logic             stall;
  logic             branch_req;
  logic             ldPC, clrPC, ldNPC, clrNPC, ldInst, clrInst;
  logic             ldDecodeInst, clrDecodeInst, ldBrnchTrgt, clrBrnchTrgt;
  logic             isBranchTaken;
  logic             busy, done;
  logic [CNT_W-1:0] inst_count;

  modport master (
    input  start, stall, branch_req,
    output ldPC, clrPC, ldNPC, clrNPC, ldInst, clrInst,
           ldDecodeInst, clrDecodeInst, ldBrnchTrgt, clrBrnchTrgt,
           isBranchTaken, busy, done, inst_count
  );

  modport slave (
    output start, stall, branch_req,
    input  ldPC, clrPC, ldNPC, clrNPC, ldInst, clrInst,
           ldDecodeInst, clrDecodeInst, ldBrnchTrgt, clrBrnchTrgt,
           isBranchTaken, busy, done, inst_count
  );
endinterface

// File: rtl/fetch_decode_ctrl.sv
// Moore sequencer for fetch/decode register strobes; stall masks strobes in fetch states.
// Branch redirect (BR/BR_PC) is built only when FETCH_DECODE_CTRL_BRANCH_EN is defined.
module fetch_decode_ctrl #(
  parameter int NUM_INST = 17,
  parameter int CNT_W    = 8
) (
  input logic                 clk,
  input logic                 reset,
  fetch_decode_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    IDLE, CLR0, CLR1, CLR2, F_PC, F_INST, F_NPC, DEC, DONE
`ifdef FETCH_DECODE_CTRL_BRANCH_EN
    , BR, BR_PC
`endif
  } state_t;

  typedef struct packed {
    logic ldPC, clrPC, ldNPC, clrNPC, ldInst, clrInst;
    logic ldDecodeInst, clrDecodeInst, ldBrnchTrgt, clrBrnchTrgt;
    logic isBranchTaken;
  } strobe_t;

  state_t           state, nextState;
  strobe_t          strb;
  logic [CNT_W-1:0] instCount;
  logic [CNT_W:0]   cntPlus1;
  logic             incCnt, clrCnt, brTake, lastInst, fetchPhase;

`ifdef FETCH_DECODE_CTRL_BRANCH_EN
  localparam state_t BR_DST = BR;
  assign brTake = bus.branch_req;
`else
  // brTake is constant 0, so BR_DST is never reached
  localparam state_t BR_DST = IDLE;
  logic unusedBranchReq;
  assign unusedBranchReq = bus.branch_req;
  assign brTake = 1'b0;
`endif

  assign cntPlus1   = {1'b0, instCount} + (CNT_W+1)'(1);
  assign lastInst   = cntPlus1 >= (CNT_W+1)'(NUM_INST);
  assign fetchPhase = state inside {F_PC, F_INST, F_NPC, DEC};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= nextState;
  end

  always_comb begin
    nextState = state;
    strb      = '0;
    incCnt    = 1'b0;
    clrCnt    = 1'b0;
    case (state)
      IDLE, DONE: if (bus.start) begin
        nextState = CLR0;
        clrCnt    = 1'b1;
      end
      CLR0: begin
        strb.clrPC   = 1'b1;
        strb.clrInst = 1'b1;
        nextState    = CLR1;
      end
      CLR1: begin
        strb.clrNPC       = 1'b1;
        strb.clrBrnchTrgt = 1'b1;
        nextState         = CLR2;
      end
      CLR2: begin
        strb.clrDecodeInst = 1'b1;
        nextState          = F_PC;
      end
      F_PC: begin
        strb.ldPC = 1'b1;
        if (brTake)          nextState = BR_DST;
        else if (!bus.stall) nextState = F_INST;
      end
      F_INST: begin
        strb.ldInst = 1'b1;
        if (brTake)          nextState = BR_DST;
        else if (!bus.stall) nextState = F_NPC;
      end
      F_NPC: begin
        strb.ldNPC = 1'b1;
        if (brTake)          nextState = BR_DST;
        else if (!bus.stall) nextState = DEC;
      end
      DEC: begin
        strb.ldDecodeInst = 1'b1;
        strb.ldBrnchTrgt  = 1'b1;
        if (brTake) begin
          nextState = BR_DST;
          incCnt    = 1'b1;
        end else if (!bus.stall) begin
          nextState = lastInst ? DONE : F_PC;
          incCnt    = 1'b1;
        end
      end
`ifdef FETCH_DECODE_CTRL_BRANCH_EN
      BR: begin
        strb.isBranchTaken = 1'b1;
        strb.clrInst       = 1'b1;
        strb.clrDecodeInst = 1'b1;
        nextState          = BR_PC;
      end
      BR_PC: begin
        strb.ldPC          = 1'b1;
        strb.isBranchTaken = 1'b1;
        nextState          = F_INST;
      end
`endif
      default: nextState = IDLE;
    endcase
    // a stalled fetch slot must not load anything; a branch overrides the stall
    if (fetchPhase && bus.stall && !brTake) strb = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                        instCount <= '0;
    else if (clrCnt)                   instCount <= '0;
    else if (incCnt && !(&instCount))  instCount <= instCount + CNT_W'(1);
  end

  assign bus.ldPC          = strb.ldPC;
  assign bus.clrPC         = strb.clrPC;
  assign bus.ldNPC         = strb.ldNPC;
  assign bus.clrNPC        = strb.clrNPC;
  assign bus.ldInst        = strb.ldInst;
  assign bus.clrInst       = strb.clrInst;
  assign bus.ldDecodeInst  = strb.ldDecodeInst;
  assign bus.clrDecodeInst = strb.clrDecodeInst;
  assign bus.ldBrnchTrgt   = strb.ldBrnchTrgt;
  assign bus.clrBrnchTrgt  = strb.clrBrnchTrgt;
  assign bus.isBranchTaken = strb.isBranchTaken;
  assign bus.busy          = (state != IDLE) && (state != DONE);
  assign bus.done          = (state == DONE);
  assign bus.inst_count    = instCount;

endmodule

// File: tb/tb_fetch_decode_ctrl.sv
// Bench for fetch_decode_ctrl: vector table, directed corner sequences, random vs. phase model.
module tb_fetch_decode_ctrl;
  localparam int NUM_INST = 17;
  localparam int CNT_W    = 8;
`ifdef FETCH_DECODE_CTRL_BRANCH_EN
  localparam bit BR_EN = 1'b1;
`else
  localparam bit BR_EN = 1'b0;
`endif

  // strobe vector bit order: ldPC clrPC ldNPC clrNPC ldInst clrInst ldDec clrDec ldBT clrBT isBT
  localparam logic [10:0] LPC = 11'h400, CPC = 11'h200, LNPC = 11'h100, CNPC = 11'h080;
  localparam logic [10:0] LIN = 11'h040, CIN = 11'h020, LDEC = 11'h010, CDEC = 11'h008;
  localparam logic [10:0] LBT = 11'h004, CBT = 11'h002, IBT  = 11'h001;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  fetch_decode_ctrl_if #(.CNT_W(CNT_W)) bus ();
  fetch_decode_ctrl #(.NUM_INST(NUM_INST), .CNT_W(CNT_W)) dut (.clk(clk), .reset(reset), .bus(bus));

  int nCmp = 0;
  int nBad = 0;

  function automatic logic [10:0] strobes();
    return {bus.ldPC, bus.clrPC, bus.ldNPC, bus.clrNPC, bus.ldInst, bus.clrInst,
            bus.ldDecodeInst, bus.clrDecodeInst, bus.ldBrnchTrgt, bus.clrBrnchTrgt,
            bus.isBranchTaken};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkOut(input string tag, input logic [10:0] es, input logic eb,
                        input logic ed, input logic [CNT_W-1:0] ec);
    chk({tag, " strobes"}, 32'(strobes()), 32'(es));
    chk({tag, " busy"},    32'(bus.busy),  32'(eb));
    chk({tag, " done"},    32'(bus.done),  32'(ed));
    chk({tag, " count"},   32'(bus.inst_count), 32'(ec));
  endtask

  // inputs are set just after a rising edge; outputs are checked at the falling edge
  task automatic stepChk(input string tag, input logic [10:0] es, input logic eb,
                         input logic ed, input logic [CNT_W-1:0] ec);
    @(negedge clk);
    chkOut(tag, es, eb, ed, ec);
    @(posedge clk); #1;
  endtask

  task automatic adv(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic doReset();
    bus.start = 1'b0; bus.stall = 1'b0; bus.branch_req = 1'b0;
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic startRun();
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  // expected strobes for cycle c of an undisturbed run (c=1 is the cycle after the start edge)
  function automatic logic [10:0] runStrb(input int c);
    if (c == 1) return CPC | CIN;
    if (c == 2) return CNPC | CBT;
    if (c == 3) return CDEC;
    if (c >= 4 && c < 4 + 4*NUM_INST)
      case ((c - 4) % 4)
        0: return LPC;
        1: return LIN;
        2: return LNPC;
        default: return LDEC | LBT;
      endcase
    return '0;
  endfunction

  // behavioural model: mode 0 idle, 1 clearing, 2 fetching, 3 redirect, 4 done
  int mMode, mSub, mCnt;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  function automatic logic [10:0] mStrb(input bit stl, input bit br);
    logic [10:0] s;
    s = '0;
    case (mMode)
      1: s = (mSub == 0) ? (CPC | CIN) : (mSub == 1) ? (CNPC | CBT) : CDEC;
      2: begin
        s = (mSub == 0) ? LPC : (mSub == 1) ? LIN : (mSub == 2) ? LNPC : (LDEC | LBT);
        if (stl && !(br && BR_EN)) s = '0;
      end
      3: s = (mSub == 0) ? (IBT | CIN | CDEC) : (LPC | IBT);
      default: s = '0;
    endcase
    return s;
  endfunction

  task automatic mStep(input bit st, input bit stl, input bit br);
    bit brE;
    bit more;
    brE = br && BR_EN;
    case (mMode)
      0, 4: if (st) begin mMode = 1; mSub = 0; mCnt = 0; end
      1: if (mSub == 2) begin mMode = 2; mSub = 0; end else mSub++;
      2: if (brE) begin
           if (mSub == 3 && mCnt < CNT_MAX) mCnt++;
           mMode = 3; mSub = 0;
         end else if (!stl) begin
           if (mSub < 3) mSub++;
           else begin
             more = (mCnt + 1) < NUM_INST;
             if (mCnt < CNT_MAX) mCnt++;
             if (more) mSub = 0; else mMode = 4;
           end
         end
      3: if (mSub == 0) mSub = 1; else begin mMode = 2; mSub = 1; end
      default: mMode = 0;
    endcase
  endtask

  typedef struct {
    logic st, stl, br;
    logic [10:0] s;
    logic busy, done;
    logic [CNT_W-1:0] cnt;
  } vec_t;
  vec_t tbl[14];

  initial begin
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 11'h000,     1'b0, 1'b0, 8'd0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 11'h000,     1'b0, 1'b0, 8'd0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, CPC | CIN,   1'b1, 1'b0, 8'd0};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, CNPC | CBT,  1'b1, 1'b0, 8'd0};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, CDEC,        1'b1, 1'b0, 8'd0};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 11'h000,     1'b1, 1'b0, 8'd0};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, LPC,         1'b1, 1'b0, 8'd0};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, LIN,         1'b1, 1'b0, 8'd0};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, LNPC,        1'b1, 1'b0, 8'd0};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, LDEC | LBT,  1'b1, 1'b0, 8'd0};
    tbl[10] = '{1'b0, 1'b0, 1'b0, LPC,         1'b1, 1'b0, 8'd1};
    tbl[11] = '{1'b1, 1'b0, 1'b0, LIN,         1'b1, 1'b0, 8'd1};
    tbl[12] = '{1'b0, 1'b0, 1'b0, LNPC,        1'b1, 1'b0, 8'd1};
    tbl[13] = '{1'b0, 1'b1, 1'b0, 11'h000,     1'b1, 1'b0, 8'd1};

    bus.start = 1'b0; bus.stall = 1'b0; bus.branch_req = 1'b0;
    #2;
    chkOut("in-reset", '0, 1'b0, 1'b0, '0);
    doReset();

    // vector table
    for (int i = 0; i < 14; i++) begin
      bus.start = tbl[i].st; bus.stall = tbl[i].stl; bus.branch_req = tbl[i].br;
      stepChk($sformatf("vec%0d", i), tbl[i].s, tbl[i].busy, tbl[i].done, tbl[i].cnt);
    end

    // full undisturbed run, then DONE hold and restart from DONE
    doReset();
    startRun();
    for (int c = 1; c <= 73; c++) begin
      if (c >= 4 + 4*NUM_INST)
        stepChk($sformatf("run c%0d", c), '0, 1'b0, 1'b1, CNT_W'(NUM_INST));
      else
        stepChk($sformatf("run c%0d", c), runStrb(c), 1'b1, 1'b0, CNT_W'(c < 4 ? 0 : (c - 4) / 4));
    end
    bus.start = 1'b1;
    stepChk("done-start", '0, 1'b0, 1'b1, CNT_W'(NUM_INST));
    bus.start = 1'b0;
    stepChk("restart", CPC | CIN, 1'b1, 1'b0, '0);

    // 3-cycle stall in F_INST
    doReset();
    startRun();
    adv(4);
    bus.stall = 1'b1;
    for (int k = 0; k < 3; k++) stepChk($sformatf("stall%0d", k), '0, 1'b1, 1'b0, '0);
    bus.stall = 1'b0;
    stepChk("stall-ldInst", LIN, 1'b1, 1'b0, '0);
    stepChk("stall-ldNPC", LNPC, 1'b1, 1'b0, '0);
    stepChk("stall-dec", LDEC | LBT, 1'b1, 1'b0, '0);
    stepChk("stall-next", LPC, 1'b1, 1'b0, 8'd1);

    // async reset in DEC with inst_count=5
    doReset();
    startRun();
    adv(26);
    #1 chkOut("pre-reset", LDEC | LBT, 1'b1, 1'b0, 8'd5);
    reset = 1'b0;
    #1 chkOut("async-reset", '0, 1'b0, 1'b0, '0);
    @(posedge clk); #1;
    reset = 1'b1;
    for (int k = 0; k < 3; k++) stepChk($sformatf("post-reset%0d", k), '0, 1'b0, 1'b0, '0);

`ifdef FETCH_DECODE_CTRL_BRANCH_EN
    // branch in F_NPC, then stall+branch together in DEC
    doReset();
    startRun();
    adv(5);
    bus.branch_req = 1'b1;
    stepChk("br-npc", LNPC, 1'b1, 1'b0, '0);
    bus.branch_req = 1'b0;
    stepChk("br-BR", IBT | CIN | CDEC, 1'b1, 1'b0, '0);
    stepChk("br-BRPC", LPC | IBT, 1'b1, 1'b0, '0);
    stepChk("br-ldInst", LIN, 1'b1, 1'b0, '0);
    stepChk("br-ldNPC", LNPC, 1'b1, 1'b0, '0);
    bus.stall = 1'b1; bus.branch_req = 1'b1;
    stepChk("brstall-dec", LDEC | LBT, 1'b1, 1'b0, '0);
    bus.stall = 1'b0; bus.branch_req = 1'b0;
    stepChk("brstall-BR", IBT | CIN | CDEC, 1'b1, 1'b0, 8'd1);
`endif

    // random stimulus against the model
    doReset();
    mMode = 0; mSub = 0; mCnt = 0;
    for (int i = 0; i < 4000; i++) begin
      logic [10:0] es;
      bus.start      = ($urandom_range(0, 9) == 0);
      bus.stall      = ($urandom_range(0, 3) == 0);
      bus.branch_req = ($urandom_range(0, 11) == 0);
      es = mStrb(bus.stall, bus.branch_req);
      @(negedge clk);
      chkOut($sformatf("rnd%0d", i), es, (mMode >= 1 && mMode <= 3), (mMode == 4), CNT_W'(mCnt));
      mStep(bus.start, bus.stall, bus.branch_req);
      @(posedge clk); #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end
endmodule
